// File: rtl/bus_pump.sv
// bus_pump: copies words from a fixed source address to a fixed
// destination address through a small FIFO, one bus access at a time.
module bus_pump #(
   parameter int                        BUS_ADDR_WIDTH = 16,
   parameter int                        BUS_CMD_WIDTH  = 3,
   parameter int                        BUS_DATA_WIDTH = 16,
   parameter int                        FIFO_DEPTH     = 4,
   parameter logic [BUS_ADDR_WIDTH-1:0] SRC_ADDR       = 'h0000,
   parameter logic [BUS_ADDR_WIDTH-1:0] DST_ADDR       = 'h0000,
   parameter bit                        SRC_MEM        = 1'b0,
   parameter bit                        DST_MEM        = 1'b0,
   parameter int                        MODE           = 0,
   parameter int                        COUNT_WIDTH    = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           enable,
   output logic                           iorq_n_,
   output logic                           mreq_n_,
   output logic [BUS_ADDR_WIDTH-1:0]      bus_addr_,
   output logic [BUS_CMD_WIDTH-1:0]       bus_cmd_,
   inout  wire  [BUS_DATA_WIDTH-1:0]      bus_data_,
   input  logic                           bus_wait_n,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
   output logic [COUNT_WIDTH-1:0]         xfer_count,
   output logic                           busy
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

   localparam logic [BUS_CMD_WIDTH-1:0] bus_cmd_none    = '0;
   localparam logic [BUS_CMD_WIDTH-1:0] bus_cmd_read_b  = BUS_CMD_WIDTH'(1);
   localparam logic [BUS_CMD_WIDTH-1:0] bus_cmd_write_b = BUS_CMD_WIDTH'(2);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WRITE
   } state_t;

   state_t                    state_q, state_d;
   logic                      fill_q, fill_d;
   logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]             level_q, level_d;
   logic [COUNT_WIDTH-1:0]    cnt_q, cnt_d;
   logic [BUS_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [BUS_DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];

   logic done;
   logic push;
   logic pop;
   logic can_read;
   logic can_write;

   assign done = (state_q != S_IDLE) && bus_wait_n;
   assign push = done && (state_q == S_READ);
   assign pop  = done && (state_q == S_WRITE);

   // FIFO bookkeeping and next-access selection at each decision edge
   always_comb begin
      state_d  = state_q;
      fill_d   = fill_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      cnt_d    = cnt_q;
      mem_d    = mem_q;

      if (push) begin
         mem_d[wr_ptr_q] = bus_data_;
         wr_ptr_d        = wr_ptr_q + PW'(1);
         level_d         = level_q + LW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
         level_d  = level_q - LW'(1);
         cnt_d    = cnt_q + COUNT_WIDTH'(1);
      end

      can_read  = enable && (level_d < DEPTH_L);
      can_write = (level_d != '0);

      if ((state_q == S_IDLE) || done) begin
         if (MODE == 0) begin
            if (state_q == S_READ) begin
               if (can_write)     state_d = S_WRITE;
               else if (can_read) state_d = S_READ;
               else               state_d = S_IDLE;
            end else begin
               if (can_read)       state_d = S_READ;
               else if (can_write) state_d = S_WRITE;
               else                state_d = S_IDLE;
            end
         end else begin
            if ((level_d == DEPTH_L) || !enable) fill_d = 1'b0;
            else if (level_d == '0)              fill_d = 1'b1;
            if (can_read && fill_d)        state_d = S_READ;
            else if (can_write && !fill_d) state_d = S_WRITE;
            else                           state_d = S_IDLE;
         end
      end
   end

   // state register; reset aborts any access in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         fill_q   <= 1'b1;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         cnt_q    <= '0;
         mem_q    <= '{default: '0};
      end else begin
         state_q  <= state_d;
         fill_q   <= fill_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         cnt_q    <= cnt_d;
         mem_q    <= mem_d;
      end
   end

   // bus command, address and space strobes decoded from state
   always_comb begin
      bus_cmd_  = bus_cmd_none;
      bus_addr_ = '0;
      iorq_n_   = 1'b1;
      mreq_n_   = 1'b1;
      unique case (state_q)
         S_READ: begin
            bus_cmd_  = bus_cmd_read_b;
            bus_addr_ = SRC_ADDR;
            iorq_n_   = SRC_MEM;
            mreq_n_   = !SRC_MEM;
         end
         S_WRITE: begin
            bus_cmd_  = bus_cmd_write_b;
            bus_addr_ = DST_ADDR;
            iorq_n_   = DST_MEM;
            mreq_n_   = !DST_MEM;
         end
         default: begin
         end
      endcase
   end

   assign bus_data_  = (state_q == S_WRITE) ? mem_q[rd_ptr_q] : 'z;
   assign fifo_level = level_q;
   assign xfer_count = cnt_q;
   assign busy       = (state_q != S_IDLE) || (level_q != '0);

endmodule

// File: tb/tb_bus_pump.sv
// tb_bus_pump: directed checks of bus_pump in alternate mode
// (instance a) and fill-then-drain mode (instance b).
module tb_bus_pump;

   localparam logic [2:0] C_NONE = 3'd0;
   localparam logic [2:0] C_RD   = 3'd1;
   localparam logic [2:0] C_WR   = 3'd2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a = 1'b1;
   logic        en_a  = 1'b0;
   logic        wn_a  = 1'b1;
   logic [15:0] src_a = 16'h1234;
   wire         iorq_a;
   wire         mreq_a;
   wire  [15:0] addr_a;
   wire  [2:0]  cmd_a;
   wire  [15:0] dat_a;
   wire  [2:0]  lvl_a;
   wire  [7:0]  cnt_a;
   wire         busy_a;

   logic        rst_b = 1'b1;
   logic        en_b  = 1'b0;
   logic        wn_b  = 1'b1;
   logic [15:0] src_b = 16'h0000;
   wire         iorq_b;
   wire         mreq_b;
   wire  [15:0] addr_b;
   wire  [2:0]  cmd_b;
   wire  [15:0] dat_b;
   wire  [2:0]  lvl_b;
   wire  [7:0]  cnt_b;
   wire         busy_b;

   assign dat_a = (cmd_a == C_RD) ? src_a : 16'hzzzz;
   assign dat_b = (cmd_b == C_RD) ? src_b : 16'hzzzz;

   bus_pump #(
      .SRC_ADDR (16'h1000),
      .DST_ADDR (16'h2000),
      .SRC_MEM  (1'b1),
      .DST_MEM  (1'b0),
      .MODE     (0)
   ) u_a (
      .clk        (clk),
      .reset      (rst_a),
      .enable     (en_a),
      .iorq_n_    (iorq_a),
      .mreq_n_    (mreq_a),
      .bus_addr_  (addr_a),
      .bus_cmd_   (cmd_a),
      .bus_data_  (dat_a),
      .bus_wait_n (wn_a),
      .fifo_level (lvl_a),
      .xfer_count (cnt_a),
      .busy       (busy_a)
   );

   bus_pump #(
      .SRC_ADDR (16'h0010),
      .DST_ADDR (16'h0020),
      .SRC_MEM  (1'b0),
      .DST_MEM  (1'b0),
      .MODE     (1)
   ) u_b (
      .clk        (clk),
      .reset      (rst_b),
      .enable     (en_b),
      .iorq_n_    (iorq_b),
      .mreq_n_    (mreq_b),
      .bus_addr_  (addr_b),
      .bus_cmd_   (cmd_b),
      .bus_data_  (dat_b),
      .bus_wait_n (wn_b),
      .fifo_level (lvl_b),
      .xfer_count (cnt_b),
      .busy       (busy_b)
   );

   int nvec = 0;
   int nmis = 0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("a_rst_cmd",  cmd_a,  C_NONE);
      chk("a_rst_lvl",  lvl_a,  0);
      chk("a_rst_cnt",  cnt_a,  0);
      chk("a_rst_iorq", iorq_a, 1);
      chk("a_rst_mreq", mreq_a, 1);
      chk("a_rst_busy", busy_a, 0);
      chk("a_rst_addr", addr_a, 0);
      chk("b_rst_cmd",  cmd_b,  C_NONE);
      chk("b_rst_busy", busy_b, 0);

      // alternate mode: R,W,R,W each cycle
      rst_a = 1'b0;
      en_a  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i % 2 == 0) begin
            chk("a_alt_rcmd",  cmd_a,  C_RD);
            chk("a_alt_raddr", addr_a, 32'h1000);
            chk("a_alt_rmreq", mreq_a, 0);
            chk("a_alt_riorq", iorq_a, 1);
            chk("a_alt_rlvl",  lvl_a,  0);
            chk("a_alt_rcnt",  cnt_a,  i / 2);
         end else begin
            chk("a_alt_wcmd",  cmd_a,  C_WR);
            chk("a_alt_waddr", addr_a, 32'h2000);
            chk("a_alt_wdat",  dat_a,  32'h1234);
            chk("a_alt_wiorq", iorq_a, 0);
            chk("a_alt_wmreq", mreq_a, 1);
            chk("a_alt_wlvl",  lvl_a,  1);
         end
      end

      // wait states during a read
      @(negedge clk);
      chk("a_ws_cmd0", cmd_a, C_RD);
      chk("a_ws_cnt0", cnt_a, 3);
      wn_a = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("a_ws_cmd",  cmd_a,  C_RD);
         chk("a_ws_addr", addr_a, 32'h1000);
         chk("a_ws_lvl",  lvl_a,  0);
      end
      wn_a  = 1'b1;
      src_a = 16'h5A5A;
      @(negedge clk);
      chk("a_ws_wcmd", cmd_a, C_WR);
      chk("a_ws_wlvl", lvl_a, 1);
      chk("a_ws_wdat", dat_a, 32'h5A5A);

      // reset lands on a stalled write
      wn_a = 1'b0;
      @(negedge clk);
      chk("a_hw_cmd", cmd_a, C_WR);
      chk("a_hw_dat", dat_a, 32'h5A5A);
      chk("a_hw_cnt", cnt_a, 3);
      rst_a = 1'b1;
      @(negedge clk);
      chk("a_rw_cmd",  cmd_a,  C_NONE);
      chk("a_rw_lvl",  lvl_a,  0);
      chk("a_rw_cnt",  cnt_a,  0);
      chk("a_rw_busy", busy_a, 0);
      chk("a_rw_iorq", iorq_a, 1);
      chk("a_rw_mreq", mreq_a, 1);
      chk("a_rw_addr", addr_a, 0);

      // counter wrap after 256 and 257 writes
      wn_a  = 1'b1;
      rst_a = 1'b0;
      src_a = 16'h00C3;
      repeat (513) @(posedge clk);
      @(negedge clk);
      chk("a_w256_cnt", cnt_a, 0);
      chk("a_w256_cmd", cmd_a, C_RD);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("a_w257_cnt", cnt_a, 1);
      chk("a_w257_cmd", cmd_a, C_RD);

      // fill-then-drain: four reads, four writes in order
      en_a  = 1'b0;
      rst_b = 1'b0;
      en_b  = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         chk("b_fill_cmd",  cmd_b,  C_RD);
         chk("b_fill_lvl",  lvl_b,  i - 1);
         chk("b_fill_addr", addr_b, 32'h0010);
         chk("b_fill_iorq", iorq_b, 0);
         chk("b_fill_mreq", mreq_b, 1);
         src_b = 16'(i);
      end
      for (int j = 1; j <= 4; j++) begin
         @(negedge clk);
         chk("b_drn_cmd",  cmd_b,  C_WR);
         chk("b_drn_dat",  dat_b,  j);
         chk("b_drn_lvl",  lvl_b,  5 - j);
         chk("b_drn_addr", addr_b, 32'h0020);
      end
      @(negedge clk);
      chk("b_res_cmd", cmd_b, C_RD);
      chk("b_res_lvl", lvl_b, 0);
      chk("b_res_cnt", cnt_b, 4);

      // enable dropped during second read
      src_b = 16'h0005;
      @(negedge clk);
      chk("b_en_cmd", cmd_b, C_RD);
      chk("b_en_lvl", lvl_b, 1);
      src_b = 16'h0006;
      en_b  = 1'b0;
      @(negedge clk);
      chk("b_en_w1cmd", cmd_b, C_WR);
      chk("b_en_w1lvl", lvl_b, 2);
      chk("b_en_w1dat", dat_b, 5);
      @(negedge clk);
      chk("b_en_w2cmd", cmd_b, C_WR);
      chk("b_en_w2lvl", lvl_b, 1);
      chk("b_en_w2dat", dat_b, 6);
      @(negedge clk);
      chk("b_en_icmd",  cmd_b,  C_NONE);
      chk("b_en_ibusy", busy_b, 0);
      chk("b_en_iiorq", iorq_b, 1);
      chk("b_en_ilvl",  lvl_b,  0);
      chk("b_en_icnt",  cnt_b,  6);
      @(negedge clk);
      chk("b_en_stay", cmd_b, C_NONE);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
